// File: rtl/cpu_ctrl_pkg.sv
// Shared state encodings, opcode constants and widths for the multi-cycle CPU controller.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OPC_W   = 5;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    AR_ALU   = 4'd2,
    AR_ROUT  = 4'd3,
    LDW_MDR  = 4'd4,
    LDW_ROUT = 4'd5,
    STW      = 4'd6,
    BR       = 4'd7,
    HALT     = 4'd8
  } state_t;

  // Register-register ALU group occupies 0..16; memory and branch ops follow.
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd2;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd3;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'd4;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'd5;
  localparam logic [OPC_W-1:0] OP_SLL  = 5'd6;
  localparam logic [OPC_W-1:0] OP_SRL  = 5'd7;
  localparam logic [OPC_W-1:0] OP_SRA  = 5'd8;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'd9;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd10;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'd11;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'd12;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'd13;
  localparam logic [OPC_W-1:0] OP_LT   = 5'd14;
  localparam logic [OPC_W-1:0] OP_GT   = 5'd15;
  localparam logic [OPC_W-1:0] OP_EQ   = 5'd16;
  localparam logic [OPC_W-1:0] OP_BR   = 5'd17;
  localparam logic [OPC_W-1:0] OP_STW  = 5'd18;
  localparam logic [OPC_W-1:0] OP_LDW  = 5'd19;

endpackage

// File: rtl/cpu_ctrl_fsm_instret_counter.sv
// Retired-instruction counter; wraps naturally at 2^CNT_W.
module instret_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM: fetch/decode/execute sequencing, memory strobes and retire count.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned OP_W    = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  input  logic               stall,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IR_EN,
  output logic               PC_EN,
  output logic               MDR_EN,
  output logic               BR_EN,
  output logic               RFwrite,
  output logic               LDW_EN,
  output logic               dataW_MDR,
  output logic               retire,
  output logic               illegal,
  output logic [CNT_W-1:0]   instret,
  output logic [STATE_W-1:0] state_o
);

  state_t          state;
  state_t          next_state;
  logic [OP_W-1:0] op;
  logic            unused_instr;

  assign op           = instr[OP_W-1:0];
  assign unused_instr = ^instr;
  assign state_o      = state;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= FETCH;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == HALT) begin
        illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IR_EN      = 1'b0;
    PC_EN      = 1'b0;
    MDR_EN     = 1'b0;
    BR_EN      = 1'b0;
    RFwrite    = 1'b0;
    LDW_EN     = 1'b0;
    dataW_MDR  = 1'b0;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        if (!stall) begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IR_EN      = 1'b1;
            PC_EN      = 1'b1;
            next_state = DECODE;
          end
        end
      end
      DECODE: begin
        // Full-width compares so any set bit above the 5-bit opcode lands in HALT.
        if (op <= OP_W'(OP_EQ))       next_state = AR_ALU;
        else if (op == OP_W'(OP_BR))  next_state = BR;
        else if (op == OP_W'(OP_STW)) next_state = STW;
        else if (op == OP_W'(OP_LDW)) next_state = LDW_MDR;
        else                          next_state = HALT;
      end
      AR_ALU:  next_state = AR_ROUT;
      AR_ROUT: begin
        RFwrite    = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      LDW_MDR: begin
        MemRead = 1'b1;
        LDW_EN  = 1'b1;
        MDR_EN  = mem_ready;
        if (mem_ready) next_state = LDW_ROUT;
      end
      LDW_ROUT: begin
        RFwrite    = 1'b1;
        dataW_MDR  = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      STW: begin
        MemWrite = 1'b1;
        LDW_EN   = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = FETCH;
        end
      end
      BR: begin
        BR_EN      = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
    // Reset kills every strobe immediately, even mid memory access.
    if (reset) begin
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IR_EN     = 1'b0;
      PC_EN     = 1'b0;
      MDR_EN    = 1'b0;
      BR_EN     = 1'b0;
      RFwrite   = 1'b0;
      LDW_EN    = 1'b0;
      dataW_MDR = 1'b0;
      retire    = 1'b0;
    end
  end

  instret_counter #(
    .CNT_W(CNT_W)
  ) u_instret (
    .CLK  (CLK),
    .reset(reset),
    .inc  (retire),
    .count(instret)
  );

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: instruction-level model expands each instruction into per-cycle expectations.
module tb_cpu_ctrl_fsm;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned CNT_W   = 4;

  localparam logic [3:0] P_FETCH = 4'd0, P_DECODE = 4'd1, P_AR_ALU = 4'd2, P_AR_ROUT = 4'd3;
  localparam logic [3:0] P_LDW_MDR = 4'd4, P_LDW_ROUT = 4'd5, P_STW = 4'd6, P_BR = 4'd7, P_HALT = 4'd8;

  // Strobe vector order: MemRead MemWrite IR_EN PC_EN MDR_EN BR_EN RFwrite LDW_EN dataW_MDR retire
  localparam logic [9:0] S_MR = 10'h200, S_MW = 10'h100, S_IR = 10'h080, S_PC = 10'h040;
  localparam logic [9:0] S_MDR = 10'h020, S_BR = 10'h010, S_RF = 10'h008, S_LDW = 10'h004;
  localparam logic [9:0] S_DMDR = 10'h002, S_RET = 10'h001, S_NONE = 10'h000;

  typedef struct packed {
    logic [9:0]       strobes;
    logic             illegal;
    logic [CNT_W-1:0] instret;
    logic [3:0]       st;
  } exp_t;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] expv;
  } lit_t;

  logic               CLK = 1'b0;
  logic               reset;
  logic [INSTR_W-1:0] instr;
  logic               mem_ready;
  logic               stall;
  logic MemRead, MemWrite, IR_EN, PC_EN, MDR_EN, BR_EN, RFwrite, LDW_EN, dataW_MDR, retire, illegal;
  logic [CNT_W-1:0]   instret;
  logic [3:0]         state_o;
  logic [9:0]         act;

  exp_t exp_q[$];
  lit_t lit_q[$];
  exp_t e;
  lit_t l;
  int   n_pass  = 0;
  int   n_total = 0;
  int   br_count = 0;
  int   actv;
  int   m_instret = 0;
  bit   m_illegal = 1'b0;

  cpu_ctrl_fsm #(
    .INSTR_W(INSTR_W),
    .OP_W   (OP_W),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK      (CLK),
    .reset    (reset),
    .instr    (instr),
    .mem_ready(mem_ready),
    .stall    (stall),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IR_EN    (IR_EN),
    .PC_EN    (PC_EN),
    .MDR_EN   (MDR_EN),
    .BR_EN    (BR_EN),
    .RFwrite  (RFwrite),
    .LDW_EN   (LDW_EN),
    .dataW_MDR(dataW_MDR),
    .retire   (retire),
    .illegal  (illegal),
    .instret  (instret),
    .state_o  (state_o)
  );

  always #5 CLK = ~CLK;

  assign act = {MemRead, MemWrite, IR_EN, PC_EN, MDR_EN, BR_EN, RFwrite, LDW_EN, dataW_MDR, retire};

  // Single compare process: per-cycle model expectations plus literal pins.
  always @(negedge CLK) begin
    if (BR_EN === 1'b1) br_count++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (act !== e.strobes || illegal !== e.illegal || instret !== e.instret || state_o !== e.st)
        $display("FAIL cycle@%0t: got strobes=%b illegal=%b instret=%0d state=%0d, required strobes=%b illegal=%b instret=%0d state=%0d",
                 $time, act, illegal, instret, state_o, e.strobes, e.illegal, e.instret, e.st);
      else
        n_pass++;
    end
    while (lit_q.size() > 0) begin
      l = lit_q.pop_front();
      n_total++;
      case (l.kind)
        2'd0:    actv = int'(instret);
        2'd1:    actv = int'(illegal);
        default: actv = br_count;
      endcase
      if (actv != int'(l.expv))
        $display("FAIL literal kind%0d (0=instret 1=illegal 2=br_pulses) @%0t: got %0d, required %0d",
                 l.kind, $time, actv, l.expv);
      else
        n_pass++;
    end
  end

  task automatic pin(input logic [1:0] kind, input int v);
    lit_t t;
    t.kind = kind;
    t.expv = 8'(v);
    lit_q.push_back(t);
  endtask

  task automatic cyc(input logic rst, input logic stl, input logic mr, input logic [INSTR_W-1:0] ins,
                     input logic [3:0] st, input logic [9:0] stb, input bit chk, input bit to_halt);
    exp_t x;
    reset = rst; stall = stl; mem_ready = mr; instr = ins;
    if (chk) begin
      x.strobes = stb;
      x.illegal = m_illegal;
      x.instret = CNT_W'(m_instret);
      x.st      = st;
      exp_q.push_back(x);
    end
    @(posedge CLK);
    #1;
    if (rst) begin
      m_instret = 0;
      m_illegal = 1'b0;
    end else begin
      if (stb[0]) m_instret = (m_instret + 1) % (1 << CNT_W);
      if (to_halt) m_illegal = 1'b1;
    end
  endtask

  // One instruction from fetch to retire; stall/mem_ready are exercised where they must be ignored.
  task automatic run_instr(input logic [INSTR_W-1:0] ins, input int n_stall, input int f_wait, input int m_wait);
    int op;
    op = int'(ins[4:0]);
    for (int i = 0; i < n_stall; i++) cyc(0, 1, 1, ins, P_FETCH, S_NONE, 1, 0);
    for (int i = 0; i < f_wait; i++)  cyc(0, 0, 0, ins, P_FETCH, S_MR, 1, 0);
    cyc(0, 0, 1, ins, P_FETCH, S_MR | S_IR | S_PC, 1, 0);
    cyc(0, 1, 1, ins, P_DECODE, S_NONE, 1, op > 19);
    if (op <= 16) begin
      cyc(0, 1, 1, ins, P_AR_ALU, S_NONE, 1, 0);
      cyc(0, 1, 1, ins, P_AR_ROUT, S_RF | S_RET, 1, 0);
    end else if (op == 17) begin
      cyc(0, 1, 1, ins, P_BR, S_BR | S_RET, 1, 0);
    end else if (op == 18) begin
      for (int i = 0; i < m_wait; i++) cyc(0, 1, 0, ins, P_STW, S_MW | S_LDW, 1, 0);
      cyc(0, 1, 1, ins, P_STW, S_MW | S_LDW | S_RET, 1, 0);
    end else if (op == 19) begin
      for (int i = 0; i < m_wait; i++) cyc(0, 1, 0, ins, P_LDW_MDR, S_MR | S_LDW, 1, 0);
      cyc(0, 1, 1, ins, P_LDW_MDR, S_MR | S_LDW | S_MDR, 1, 0);
      cyc(0, 1, 1, ins, P_LDW_ROUT, S_RF | S_DMDR | S_RET, 1, 0);
    end
  endtask

  task automatic halt_then_reset(input logic [INSTR_W-1:0] ins);
    run_instr(ins, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, i[0], 1, ins, P_HALT, S_NONE, 1, 0);
    pin(2'd1, 1);
    cyc(1, 0, 1, ins, P_HALT, S_NONE, 1, 0);
    cyc(0, 0, 0, ins, P_FETCH, S_MR, 1, 0);
    pin(2'd1, 0);
  endtask

  initial begin
    cyc(1, 0, 1, 16'h0000, P_FETCH, S_NONE, 0, 0);
    cyc(1, 0, 1, 16'h0000, P_FETCH, S_NONE, 1, 0);
    pin(2'd0, 0);

    run_instr(16'h0000, 0, 0, 0);
    pin(2'd0, 1);
    run_instr(16'hABD0, 0, 2, 0);
    run_instr(16'h0013, 0, 0, 3);
    pin(2'd0, 3);
    run_instr(16'h0012, 0, 0, 0);
    run_instr(16'hFFF2, 0, 1, 2);
    run_instr(16'h0011, 0, 0, 0);
    run_instr(16'h0003, 5, 0, 0);
    pin(2'd0, 7);
    pin(2'd2, 1);

    for (int i = 0; i < 16; i++) begin
      run_instr(16'h0011, 0, 0, 0);
      if (i == 8) pin(2'd0, 0);
    end
    pin(2'd0, 7);
    pin(2'd2, 17);

    cyc(0, 0, 1, 16'h0012, P_FETCH, S_MR | S_IR | S_PC, 1, 0);
    cyc(0, 0, 1, 16'h0012, P_DECODE, S_NONE, 1, 0);
    cyc(0, 0, 0, 16'h0012, P_STW, S_MW | S_LDW, 1, 0);
    cyc(1, 0, 0, 16'h0012, P_STW, S_NONE, 1, 0);
    cyc(0, 0, 0, 16'h0012, P_FETCH, S_MR, 1, 0);
    pin(2'd0, 0);

    halt_then_reset(16'h0014);
    halt_then_reset(16'h001F);

    cyc(0, 1, 1, 16'h0000, P_FETCH, S_NONE, 1, 0);
    run_instr(16'h0010, 0, 0, 0);
    pin(2'd0, 1);
    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 SHALL have parameter INSTR_W, default 16: instruction width.
REQ-002 SHALL have parameter OP_W, default 5: opcode field width, taken from instr[OP_W-1:0]; range 5..INSTR_W.
REQ-003 SHALL have parameter CNT_W, default 16: retired-instruction counter width.
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports are CLK and reset.
REQ-005 Ports SHALL be:
 CLK  in  1  clock
 reset  in  1  synchronous, active-high
 instr  in  INSTR_W  IR contents
 mem_ready  in  1  memory completes the current read or write this cycle
 stall  in  1  hold off instruction fetch
 MemRead, MemWrite  out  1 each  memory strobes
 IR_EN, PC_EN, MDR_EN, BR_EN, RFwrite  out  1 each  register enables
 LDW_EN  out  1  memory address mux selects the register operand
 dataW_MDR  out  1  RF write data mux selects the MDR
 retire  out  1  one-cycle pulse per completed instruction
 illegal  out  1  sticky illegal-opcode flag
 instret  out  CNT_W  retired-instruction count
 state_o  out  4  current state encoding

Function
REQ-006 States and encodings SHALL be FETCH=0, DECODE=1, AR_ALU=2, AR_ROUT=3, LDW_MDR=4, LDW_ROUT=5, STW=6, BR=7, HALT=8. Encodings 9-15 SHALL go to FETCH on the next cycle, with all strobes 0.
REQ-007 All strobes SHALL default to 0. Strobes SHALL be decoded from the current state only; the exceptions are the mem_ready-qualified strobes named below.
REQ-008 FETCH with stall=1: all strobes SHALL be 0 and the state SHALL hold. stall SHALL be ignored in every other state.
REQ-009 FETCH with stall=0:
 - MemRead=1 every cycle.
 - mem_ready=0: the state SHALL hold.
 - mem_ready=1: IR_EN=1 and PC_EN=1 for that cycle only, then go to DECODE.
REQ-010 DECODE SHALL assert no strobes. It SHALL branch on op = instr[OP_W-1:0]:
 - op<=16 -> AR_ALU
 - op=17 -> BR
 - op=18 -> STW
 - op=19 -> LDW_MDR
 - any other value, including any nonzero bit above bit 4 -> HALT, and set illegal.
REQ-011 AR_ALU SHALL assert no strobes and go to AR_ROUT. AR_ROUT SHALL assert RFwrite=1 and retire=1, then go to FETCH.
REQ-012 LDW_MDR SHALL assert MemRead=1 and LDW_EN=1 every cycle. MDR_EN SHALL equal mem_ready. The state SHALL hold until mem_ready=1, then go to LDW_ROUT.
REQ-013 LDW_ROUT SHALL assert RFwrite=1, dataW_MDR=1 and retire=1, then go to FETCH.
REQ-014 STW SHALL assert MemWrite=1 and LDW_EN=1 every cycle. It SHALL hold until mem_ready=1; in that cycle retire=1, then go to FETCH.
REQ-015 BR SHALL assert BR_EN=1 and retire=1 for one cycle, then go to FETCH.
REQ-016 HALT SHALL assert no strobes, hold illegal=1, and remain in HALT until reset.
REQ-017 instret SHALL increment by 1 in every cycle with retire=1, wrapping from 2^CNT_W-1 to 0.
REQ-018 MemRead and MemWrite SHALL never be 1 in the same cycle.
REQ-019 mem_ready=1 in a state that does not access memory SHALL have no effect.
REQ-020 Minimum latency, with mem_ready=1 on the first cycle of each access:
 - ALU op: 4 cycles
 - LDW: 4 cycles
 - STW: 3 cycles
 - BR: 3 cycles

Reset
REQ-021 When reset=1 at a CLK edge: state SHALL become FETCH, illegal SHALL become 0, and instret SHALL become 0.
REQ-022 While reset=1, all strobes and retire SHALL be 0, whatever the state, including mid memory access.
REQ-023 From the first cycle after reset deasserts, outputs SHALL be those of FETCH: MemRead=1 unless stall=1.

Structure
REQ-024 A shared package cpu_ctrl_pkg SHALL hold:
 - the state encodings
 - opcode constants OP_ADD=0 through OP_EQ=16, OP_BR=17, OP_STW=18, OP_LDW=19
 - the 4-bit state width.
REQ-025 The counter SHALL be the single sub-module instret_counter, parameterised by CNT_W, with inputs CLK, reset and inc, and output count.

Verification
REQ-026 ADD (op=0), mem_ready tied 1 -> cycle 1 MemRead/IR_EN/PC_EN; cycle 2 no strobes (DECODE); cycle 3 no strobes; cycle 4 RFwrite=1, retire=1; instret 0->1.
REQ-027 LDW (op=19), mem_ready low 3 cycles in LDW_MDR -> MemRead and LDW_EN held 4 cycles; MDR_EN=1 only in the 4th; then RFwrite=1 and dataW_MDR=1 for 1 cycle.
REQ-028 op=20, and op=5'b11111 -> HALT; illegal=1; all strobes 0 for 10+ cycles; reset clears illegal and state_o=0.
REQ-029 stall=1 for 5 cycles in FETCH, then 0 -> no MemRead during the stall; MemRead=1 on the first cycle after the stall.
REQ-030 CNT_W=4: 16 BR instructions -> instret wraps 15->0; BR_EN pulses exactly 16 times.
REQ-031 reset asserted in STW while mem_ready=0 -> MemWrite=0 in the reset cycle; state_o=0 next cycle; instret unchanged by the aborted store.
